// File: rtl/vliw_issue_scoreboard.sv
// Issue stage for NSLOT-wide VLIW bundles: accepts one bundle per cycle and holds it
// back while any operand or destination is still covered by a per-register countdown.
module vliw_issue_scoreboard #(
    parameter int                 NSLOT    = 10,
    parameter int                 NREG     = 32,
    parameter logic [NSLOT*3-1:0] SLOT_LAT = {NSLOT{3'd2}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [NSLOT*32-1:0]   bundle_in,
    input  logic                  bundle_valid,
    output logic                  bundle_ready,
    output logic [NSLOT*32-1:0]   issue_bundle,
    output logic                  issue_valid,
    output logic                  busy,
    output logic                  wr_conflict,
    output logic [15:0]           stall_count
);

    typedef struct packed {
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] payload;
    } slot_t;

    slot_t               slot [NSLOT];
    logic [2:0]          cnt_q [NREG];
    logic [2:0]          cnt_d [NREG];
    logic [NSLOT*32-1:0] issue_bundle_q, issue_bundle_d;
    logic                issue_valid_q, issue_valid_d;
    logic                busy_q, busy_d;
    logic                wr_conflict_q, wr_conflict_d;
    logic [15:0]         stall_count_q, stall_count_d;
    logic                hazard;
    logic                dup_rd;
    logic                accept;

    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            slot[i] = slot_t'(bundle_in[32*i +: 32]);
        end
    end

    // NOTE: every always_comb output gets a default before any conditional update,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (slot[i].opcode != 5'd0 &&
                (cnt_q[slot[i].rd]  != 3'd0 ||
                 cnt_q[slot[i].rs1] != 3'd0 ||
                 cnt_q[slot[i].rs2] != 3'd0)) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        dup_rd = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            for (int j = i + 1; j < NSLOT; j++) begin
                if (slot[i].opcode != 5'd0 && slot[j].opcode != 5'd0 &&
                    slot[i].rd == slot[j].rd) begin
                    dup_rd = 1'b1;
                end
            end
        end
    end

    assign bundle_ready = ~rst & ~flush & ~hazard;
    assign accept       = bundle_valid & bundle_ready;

    // Ascending slot order lets the highest-index writer of a duplicated rd win.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != 3'd0) ? cnt_q[r] - 3'd1 : 3'd0;
        end
        if (accept) begin
            for (int i = 0; i < NSLOT; i++) begin
                if (slot[i].opcode != 5'd0 && SLOT_LAT[3*i +: 3] != 3'd0) begin
                    cnt_d[slot[i].rd] = SLOT_LAT[3*i +: 3];
                end
            end
        end
        if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_d[r] = 3'd0;
            end
        end
        busy_d = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            busy_d = busy_d | (cnt_d[r] != 3'd0);
        end
    end

    always_comb begin
        issue_valid_d  = accept;
        issue_bundle_d = accept ? bundle_in : issue_bundle_q;
        wr_conflict_d  = accept & dup_rd;
        stall_count_d  = stall_count_q;
        if (bundle_valid && !bundle_ready && !flush && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the counter array is real flops and must be cleared on reset,
    // since a stale count would block issue forever.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= 3'd0;
            end
            issue_bundle_q <= '0;
            issue_valid_q  <= 1'b0;
            busy_q         <= 1'b0;
            wr_conflict_q  <= 1'b0;
            stall_count_q  <= 16'd0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            issue_bundle_q <= issue_bundle_d;
            issue_valid_q  <= issue_valid_d;
            busy_q         <= busy_d;
            wr_conflict_q  <= wr_conflict_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign issue_bundle = issue_bundle_q;
    assign issue_valid  = issue_valid_q;
    assign busy         = busy_q;
    assign wr_conflict  = wr_conflict_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_vliw_issue_scoreboard.sv
// Self-checking bench for vliw_issue_scoreboard: directed scenarios then random bundles,
// compared against a model that tracks, per register, the edge at which it frees up.
module tb_vliw_issue_scoreboard;

    localparam int NSLOT = 10;
    localparam int NREG  = 32;
    localparam int BW    = NSLOT * 32;
    // Slot latencies, slot 9 first: s0=2 s1=1 s2=2 s3=0 s4=4 s5=2 s6=7 s7=2 s8=2 s9=2
    localparam logic [NSLOT*3-1:0] LAT_VEC =
        {3'd2, 3'd2, 3'd2, 3'd7, 3'd2, 3'd4, 3'd0, 3'd2, 3'd1, 3'd2};

    int lat_tab [NSLOT] = '{2, 1, 2, 0, 4, 2, 7, 2, 2, 2};

    logic          clk;
    logic          rst;
    logic          flush;
    logic [BW-1:0] bundle_in;
    logic          bundle_valid;
    logic          bundle_ready;
    logic [BW-1:0] issue_bundle;
    logic          issue_valid;
    logic          busy;
    logic          wr_conflict;
    logic [15:0]   stall_count;

    vliw_issue_scoreboard #(
        .NSLOT    (NSLOT),
        .NREG     (NREG),
        .SLOT_LAT (LAT_VEC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bundle_in    (bundle_in),
        .bundle_valid (bundle_valid),
        .bundle_ready (bundle_ready),
        .issue_bundle (issue_bundle),
        .issue_valid  (issue_valid),
        .busy         (busy),
        .wr_conflict  (wr_conflict),
        .stall_count  (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: a register written with latency L at edge E is free again
    // for any edge strictly after E+L.
    int            free_at [NREG];
    int            edge_n;
    logic [BW-1:0] exp_ib;
    logic          exp_iv;
    logic          exp_busy;
    logic          exp_wc;
    int            exp_stall;
    int            checks;
    int            errors;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2);
        logic [31:0] s;
        s[31:27] = op[4:0];
        s[26:22] = rd[4:0];
        s[21:17] = rs1[4:0];
        s[16:12] = rs2[4:0];
        s[11:0]  = 12'hA5C;
        return s;
    endfunction

    function automatic logic model_hazard(input logic [BW-1:0] b);
        logic [31:0] s;
        logic        h;
        h = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            s = b[32*i +: 32];
            if (s[31:27] != 5'd0) begin
                if (free_at[s[26:22]] >= edge_n || free_at[s[21:17]] >= edge_n ||
                    free_at[s[16:12]] >= edge_n) h = 1'b1;
            end
        end
        return h;
    endfunction

    function automatic logic model_dup(input logic [BW-1:0] b);
        int          seen [NREG];
        logic [31:0] s;
        logic        d;
        d = 1'b0;
        for (int r = 0; r < NREG; r++) seen[r] = 0;
        for (int i = 0; i < NSLOT; i++) begin
            s = b[32*i +: 32];
            if (s[31:27] != 5'd0) seen[s[26:22]]++;
        end
        for (int r = 0; r < NREG; r++) if (seen[r] > 1) d = 1'b1;
        return d;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < NREG; r++) free_at[r] = -1;
    endfunction

    // Called in the low clock phase; returns in the next low phase.
    task automatic cycle(input logic fl, input logic vld, input logic [BW-1:0] b,
                         output logic dut_acc);
        logic exp_rdy;
        logic acc;
        logic [31:0] s;
        flush        = fl;
        bundle_valid = vld;
        bundle_in    = b;
        #1;
        exp_rdy = !fl && !model_hazard(b);
        check("bundle_ready", bundle_ready, exp_rdy);
        dut_acc = vld && bundle_ready;
        acc     = vld && exp_rdy;
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else if (acc) begin
            for (int i = 0; i < NSLOT; i++) begin
                s = b[32*i +: 32];
                if (s[31:27] != 5'd0 && lat_tab[i] > 0) free_at[s[26:22]] = edge_n + lat_tab[i];
            end
            exp_ib = b;
        end
        exp_iv = acc;
        exp_wc = acc && model_dup(b);
        if (vld && !exp_rdy && !fl && exp_stall < 65535) exp_stall++;
        exp_busy = 1'b0;
        for (int r = 0; r < NREG; r++) if (free_at[r] > edge_n) exp_busy = 1'b1;
        edge_n++;
        #1;
        check("issue_valid", issue_valid, exp_iv);
        check("issue_bundle", issue_bundle, exp_ib);
        check("busy", busy, exp_busy);
        check("wr_conflict", wr_conflict, exp_wc);
        check("stall_count", stall_count, exp_stall);
        @(negedge clk);
    endtask

    task automatic present_until_accept(input logic [BW-1:0] b, output int waits);
        logic acc;
        waits = 0;
        acc   = 1'b0;
        while (!acc && waits <= 20) begin
            cycle(1'b0, 1'b1, b, acc);
            if (!acc) waits++;
        end
        if (!acc) check("accept_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, acc);
    endtask

    task automatic model_reset();
        model_clear();
        exp_ib    = '0;
        exp_iv    = 1'b0;
        exp_busy  = 1'b0;
        exp_wc    = 1'b0;
        exp_stall = 0;
    endtask

    // Asynchronous reset pulse inside the low phase, never spanning a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_bundle_ready", bundle_ready, 1'b0);
        check("rst_issue_valid", issue_valid, 1'b0);
        check("rst_issue_bundle", issue_bundle, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_conflict", wr_conflict, 1'b0);
        check("rst_stall_count", stall_count, 16'd0);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [BW-1:0] bun_a;
        logic [BW-1:0] bun_b;
        logic [BW-1:0] bun_x;
        logic [BW-1:0] bun_d;
        logic [BW-1:0] rnd;
        logic          acc;
        logic          fl;
        logic          vld;
        int            waits;
        int            stall_before;

        checks       = 0;
        errors       = 0;
        edge_n       = 0;
        rst          = 1'b1;
        flush        = 1'b0;
        bundle_valid = 1'b0;
        bundle_in    = '0;
        model_reset();

        @(negedge clk);
        do_reset();

        // Three all-NOP bundles back to back
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, '0, acc);

        // RAW: A writes r5 from slot 5 (latency 2), B reads r5 in slot 2
        bun_a = '0;
        bun_a[32*5 +: 32] = mk(5'b10010, 5, 1, 2);
        bun_b = '0;
        bun_b[32*2 +: 32] = mk(1, 7, 5, 3);
        cycle(1'b0, 1'b1, bun_a, acc);
        present_until_accept(bun_b, waits);
        check("raw_stall_cycles", waits, 2);
        check("raw_stall_count", stall_count, 16'd2);
        check("raw_issue_bundle", issue_bundle, bun_b);
        idle(4);

        // WAW on r3 from slot 0 (latency 2)
        bun_x = '0;
        bun_x[32*0 +: 32] = mk(3, 3, 10, 11);
        cycle(1'b0, 1'b1, bun_x, acc);
        bun_x[32*0 +: 32] = mk(4, 3, 12, 13);
        present_until_accept(bun_x, waits);
        check("waw_stall_cycles", waits, 2);
        idle(4);

        // Duplicate rd r9 from slot 1 (latency 1) and slot 4 (latency 4)
        bun_x = '0;
        bun_x[32*1 +: 32] = mk(2, 9, 1, 2);
        bun_x[32*4 +: 32] = mk(6, 9, 1, 2);
        cycle(1'b0, 1'b1, bun_x, acc);
        check("dup_wr_conflict", wr_conflict, 1'b1);
        bun_x = '0;
        bun_x[32*0 +: 32] = mk(1, 15, 9, 14);
        present_until_accept(bun_x, waits);
        check("dup_reader_stalls", waits, 4);
        idle(4);

        // Latency-0 producer places no restriction
        bun_x = '0;
        bun_x[32*3 +: 32] = mk(7, 20, 1, 2);
        cycle(1'b0, 1'b1, bun_x, acc);
        bun_x = '0;
        bun_x[32*0 +: 32] = mk(1, 22, 20, 20);
        present_until_accept(bun_x, waits);
        check("lat0_reader_stalls", waits, 0);
        idle(4);

        // Flush while r5 pending; the dependent (latency-0 slot) issues right after
        bun_d = '0;
        bun_d[32*3 +: 32] = mk(8, 21, 5, 6);
        cycle(1'b0, 1'b1, bun_a, acc);
        stall_before = exp_stall;
        cycle(1'b1, 1'b1, bun_d, acc);
        check("flush_no_accept", issue_valid, 1'b0);
        check("flush_no_stall_inc", stall_count, 16'(stall_before));
        present_until_accept(bun_d, waits);
        check("flush_dep_stalls", waits, 0);
        check("flush_busy", busy, 1'b0);
        idle(2);

        // Asynchronous reset in the middle of a stall
        cycle(1'b0, 1'b1, bun_a, acc);
        cycle(1'b0, 1'b1, bun_b, acc);
        check("prereset_stalled", acc, 1'b0);
        do_reset();
        present_until_accept(bun_b, waits);
        check("postreset_stalls", waits, 0);
        idle(4);

        // Random bundles over a small register window to provoke hazards
        for (int k = 0; k < 400; k++) begin
            rnd = '0;
            for (int i = 0; i < NSLOT; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rnd[32*i +: 32] = mk(int'($urandom_range(1, 31)), int'($urandom_range(0, 7)),
                                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
                end
            end
            fl  = ($urandom_range(0, 15) == 0);
            vld = ($urandom_range(0, 3) != 0);
            cycle(fl, vld, rnd, acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vliw_issue_scoreboard.md
# vliw_issue_scoreboard

Issue controller that sits between the instruction memory fetch stage and the VLIW execute slots of `processor`. It accepts one 320-bit bundle (10 × 32-bit slots) per cycle through a valid/ready handshake. It holds a bundle back while any of its register operands or destinations is still being produced by an earlier bundle. A per-register countdown scoreboard tracks in-flight results using a fixed per-slot latency.

## Interface
Parameters:
- `NSLOT`, 10: slots per bundle; slot i = `bundle[32*i+31 : 32*i]`.
- `NREG`, 32: architectural registers, indexed by 5-bit fields.
- `SLOT_LAT`, all slots 3'd2: packed `NSLOT*3`-bit vector; bits [3i+2:3i] give the result latency of slot i (0–7).

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `flush`  in  1: synchronous scoreboard clear.
- `bundle_in`  in  320: candidate bundle.
- `bundle_valid`  in  1: `bundle_in` is valid.
- `bundle_ready`  out  1: combinational; bundle is accepted on this edge.
- `issue_bundle`  out  320: registered issued bundle.
- `issue_valid`  out  1: `issue_bundle` is valid this cycle (downstream always accepts).
- `busy`  out  1: registered; any scoreboard counter is nonzero.
- `wr_conflict`  out  1: registered one-cycle pulse when an accepted bundle had two slots with the same rd.
- `stall_count`  out  16: saturating count of cycles with `bundle_valid & ~bundle_ready`.

## Operation
- Slot decode: [31:27] opcode (5'b0 = NOP, ignored entirely), [26:22] rd, [21:17] rs1, [16:12] rs2. All 32 registers are tracked, including r0.
- Scoreboard: `cnt[r]`, 3 bits per register. Register r is ready when `cnt[r] == 0`.
- Hazard: for every non-NOP slot, rs1, rs2 or rd has a nonzero count. This covers RAW and WAW. Reads within a bundle see pre-bundle state, so no intra-bundle RAW check is made.
- `bundle_ready = ~rst & ~flush & ~hazard`. `bundle_ready` does not depend on `bundle_valid`.
- Accept = `bundle_valid & bundle_ready`. On accept:
  - `issue_bundle` ← `bundle_in` and `issue_valid` ← 1.
  - For each non-NOP slot with `SLOT_LAT` > 0, `cnt[rd]` ← that latency. Slots with latency 0 load nothing.
- Without accept, `issue_valid` ← 0 and `issue_bundle` holds its value.
- Duplicate rd in one accepted bundle: the highest-index slot's latency is loaded, and `wr_conflict` pulses for 1 cycle.
- Counters not being loaded decrement by 1 per cycle when nonzero. A load takes priority over a decrement, which cannot coincide anyway because a loaded rd was 0.
- `flush`: on the edge, all `cnt` ← 0 and `issue_valid` ← 0. The bundle present during flush is not accepted, and `stall_count` is not incremented.
- `stall_count` saturates at 16'hFFFF.

## Timing
- Reset values: all `cnt` = 0, `issue_valid` = 0, `issue_bundle` = 0, `busy` = 0, `wr_conflict` = 0, `stall_count` = 0. `bundle_ready` = 0 while `rst` is high.
- Reset asserted mid-operation: all state clears immediately, and in-flight hazards are forgotten.
- Accept-to-issue latency is 1 cycle: a bundle accepted at edge E appears on `issue_bundle` with `issue_valid` = 1 after E.
- Producer accepted at edge E with latency L ≥ 1:
  - `cnt` = L after E and reaches 0 after E+L.
  - A dependent bundle is accepted no earlier than E+L+1, i.e. L stall cycles when presented back-to-back.
- Latency 0 places no restriction: a dependent bundle can be accepted at E+1.
- Back-to-back independent bundles are accepted every cycle with no bubbles.
- `busy` reflects the post-edge counter state, registered alongside `cnt`.

## Test plan
- Reset, then present all-NOP bundles for 3 cycles with valid = 1 → `bundle_ready` = 1 each cycle, `issue_valid` = 1 for 3 cycles, `busy` = 0, `stall_count` = 0.
- Bundle A: slot 5 = 32'b10010_00101_… (rd = r5, latency 2). Next cycle, bundle B: slot 2 reads rs1 = r5, rs2 = r3 and writes rd = r7. → A accepted at E. B stalls 2 cycles (`stall_count` = 2) and is accepted at E+3. `issue_bundle` = B after E+3.
- WAW: bundle writes r3; the next bundle also writes r3 with all other registers independent → second bundle accepted exactly 3 edges after the first.
- Duplicate rd: slots 1 and 4 both write r9, with latencies 1 and 4 → `wr_conflict` = 1 for 1 cycle. A reader of r9 is accepted at E+5.
- Flush while r5 is pending (`cnt` = 2) with a dependent bundle valid → no accept on the flush edge. Next edge: the dependent bundle is accepted and `busy` = 0.
- Assert `rst` asynchronously mid-stall → `issue_valid`, `busy`, `stall_count` and `issue_bundle` read 0 before the next clock edge. After release, the stalled bundle is accepted on the first edge.
